// File: rtl/dbus_mem_responder_pkg.sv
// dbus_mem_responder_pkg: data-bus request/response types and responder FSM state
package dbus_mem_responder_pkg;
  localparam int DMEM_LAT_W = 4;
  typedef enum logic [2:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

// File: rtl/dbus_mem_responder_dmem_array.sv
// dbus_mem_responder_dmem_array: 64-bit word storage, combinational read, byte-strobed sync write
module dbus_mem_responder_dmem_array #(
  parameter int WORDS = 4096,
  parameter int AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] idx_i,
  input  logic [7:0]    strobe_i,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   rdata_o
);
  logic [63:0] mem_q [WORDS];
  assign rdata_o = mem_q[idx_i];
  // commit only the byte lanes selected by the strobe
  always_ff @(posedge clk)
    for (int b = 0; b < 8; b++)
      if (we_i && strobe_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
endmodule

// File: rtl/dbus_mem_responder.sv
// dbus_mem_responder: single-outstanding data-bus responder with programmable latency over an SRAM model
module dbus_mem_responder
  import dbus_mem_responder_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter int          LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [DMEM_LAT_W-1:0] CNT_INIT = DMEM_LAT_W'(LATENCY > 1 ? LATENCY - 2 : 0);
  dmem_state_t           state_q;
  logic [DMEM_LAT_W-1:0] cnt_q;
  logic [63:0]           addr_q, wdata_q;
  logic [7:0]            strobe_q;
  dbus_resp_t            resp_q;
  logic                  err_q;
  logic [63:0]           addr_s, off, rdata;
  logic [AW-1:0]         idx;
  logic                  in_range, go_resp, we, unused_ok;
  // in IDLE the live request is decoded so a LATENCY=1 response can be registered at acceptance
  assign addr_s   = state_q == IDLE ? dreq.addr : addr_q;
  assign off      = addr_s - BASE_ADDR;
  assign in_range = addr_s >= BASE_ADDR && off[63:3] < 61'(MEM_WORDS);
  assign idx      = off[3 +: AW];
  assign go_resp  = (state_q == IDLE && dreq.valid && LATENCY == 1) || (state_q == WAIT && cnt_q == 0);
  assign we       = reset && state_q == RESP && in_range;
  assign unused_ok = ^{off[2:0], dreq.size};
  assign dresp    = resp_q;
  assign err      = err_q;
  dbus_mem_responder_dmem_array #(.WORDS(MEM_WORDS)) u_array (
    .clk      (clk),
    .we_i     (we),
    .idx_i    (idx),
    .strobe_i (strobe_q),
    .wdata_i  (wdata_q),
    .rdata_o  (rdata)
  );
  // request capture, latency countdown and registered response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strobe_q <= '0;
      resp_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      resp_q.addr_ok <= go_resp;
      resp_q.data_ok <= go_resp;
      resp_q.data    <= go_resp && in_range ? rdata : '0;
      err_q          <= go_resp && !in_range;
      case (state_q)
        IDLE: if (dreq.valid) begin
          addr_q   <= dreq.addr;
          wdata_q  <= dreq.data;
          strobe_q <= dreq.strobe;
          cnt_q    <= CNT_INIT;
          state_q  <= LATENCY == 1 ? RESP : WAIT;
        end
        WAIT: if (cnt_q == 0) state_q <= RESP;
              else cnt_q <= cnt_q - 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dbus_mem_responder.md
# dbus_mem_responder

Data-bus responder that serves the core's `dbus_req_t`/`dbus_resp_t` memory port from a private on-chip SRAM model. It captures one request at a time, waits a programmable number of cycles, then returns a one-cycle `data_ok` with read data and commits byte-strobed writes. It sits outside `core`, in the simulation/SoC top, as the far end of `dreq`/`dresp`. It also serves as a latency-injection model for verifying stall handling in the memory stage.

## Interface
- `MEM_WORDS`, 4096: number of 64-bit words in the array; power of two.
- `LATENCY`, 2: cycles from request acceptance to `data_ok`; legal range 1..15.
- `BASE_ADDR`, 64'h8000_0000: byte address of word 0.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. The block is in reset while `reset`=0.
- `dreq`  in  `dbus_req_t`  fields `valid`, `addr`[63:0], `size`, `strobe`[7:0], `data`[63:0].
- `dresp`  out  `dbus_resp_t`  fields `addr_ok`, `data_ok`, `data`[63:0].
- `err`  out  1  one-cycle pulse, coincident with `data_ok`, for an out-of-range access.

## Operation
- FSM states and transitions:
  - IDLE → WAIT on `dreq.valid`=1 when `LATENCY`>1.
  - IDLE → RESP on `dreq.valid`=1 when `LATENCY`=1.
  - WAIT → RESP when the counter reaches 0.
  - RESP → IDLE unconditionally.
- Acceptance happens only in IDLE. On acceptance the block captures `addr`, `strobe` and `data` and loads the counter with `LATENCY`-2 (or goes straight to RESP when `LATENCY`=1). WAIT decrements the counter each cycle.
- RESP lasts exactly one cycle, with `dresp.addr_ok`=`dresp.data_ok`=1 and `dresp.data` = the aligned doubleword at the captured word index.
- Word index = (captured `addr` − `BASE_ADDR`) >> 3. Bits [2:0] of the address are ignored. `size` is informational only; the initiator lane-aligns `strobe`/`data`.
- Writes: in RESP, each byte *i* whose `strobe`[i]=1 is written at the clock edge that ends RESP. Read data in RESP is the pre-write contents. `strobe`=0 is a pure read.
- Out of range: an address below `BASE_ADDR`, or a word index ≥ `MEM_WORDS`. The response still completes with `data`=0 and `err`=1, and no array write occurs.
- The initiator must hold `dreq` stable until `data_ok`. The responder uses only the captured copy, so changes or a drop of `valid` during WAIT/RESP are ignored and the transaction still completes.
- If `valid` is still high in the cycle after RESP, that is a new request and is accepted again (a stalled pipeline repeating a load or store is legal).

## Timing
- Reset values: state=IDLE, counter=0, `dresp.addr_ok`=0, `dresp.data_ok`=0, `dresp.data`=0, `err`=0. Array contents are not reset.
- Latency: if `valid` is sampled high in IDLE at edge *t*, `data_ok` is high during cycle *t*+`LATENCY` only.
- Throughput: one transaction per `LATENCY`+1 cycles under continuous `valid`.
- All outputs are registered; `data_ok` and `err` are never high for two consecutive cycles.
- Reset asserted in WAIT or RESP: the FSM returns to IDLE immediately, no `data_ok` is issued, and the pending write is dropped. An array write at the same edge as reset assertion must not occur.
- Counter width is 4 bits; `LATENCY`=15 gives a maximum WAIT of 14 cycles with no wrap.

## Structure
- Shared package `common`:
  - `dmem_state_t` enum (IDLE, WAIT, RESP).
  - `DMEM_LAT_W`=4.
  - Reuse of the existing `dbus_req_t`, `dbus_resp_t` and `msize_t`.
- Sub-module `dmem_array`: `MEM_WORDS`×64 storage with a combinational read port and a synchronous byte-strobed write port. Write enable is gated by the FSM and the range check.
- The FSM, capture registers and range check live in the top module.

## Test plan
- `LATENCY`=2: store `data`=64'h1122_3344_5566_7788, `strobe`=8'hFF to 64'h8000_0010 → `data_ok` 2 cycles after acceptance. A subsequent load returns 64'h1122_3344_5566_7788.
- Partial write `strobe`=8'h0F, `data`=64'hAAAA_AAAA_BBBB_BBBB over the same word → reload returns 64'h1122_3344_BBBB_BBBB.
- `LATENCY`=1 with `valid` held high for 6 cycles → exactly 3 `data_ok` pulses at cycles 1, 3 and 5.
- Load from 64'h7FFF_FFF8 and from `BASE_ADDR`+8×`MEM_WORDS` → `data`=0 and `err`=1 with `data_ok`. Array contents unchanged.
- `dreq.addr` changed and `valid` dropped during WAIT → the response still uses the original address and arrives on schedule.
- `reset` pulled low during WAIT of a store → no `data_ok`, the word keeps its old value, and all outputs read 0 while `reset` is low.
